toggle_cover_detect: RTL and testbench

- Upstream producer for the 64-point toggle-coverage reporter.
- Samples a monitored signal vector, detects per-bit rise and fall transitions, and masks points that are already covered.
- Drives a registered 64-bit cover-valid vector that connects directly to the reporter's valid input.
- Also keeps a running covered-point count and supports a clear handshake between test phases.

---
 rtl/toggle_cover_detect.sv | 149 ++++++++++++++
 tb/tb_toggle_cover_detect.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/toggle_cover_detect.sv
// toggle_cover_detect
// Producer for the toggle-coverage reporter. It samples a monitored vector,
// finds per-bit rise and fall transitions and reports each cover point as a
// one-cycle pulse on valid_out. With DEDUP=1, points that are already covered
// are masked. It also keeps a count of distinct covered points, and a
// clear_req / clear_ack handshake resets that count between test phases.
//
// Ports:
//   gbl_clk      clock
//   reset        synchronous, active-low reset
//   sig_in       monitored signal (SIG_WIDTH bits)
//   sample_en    sig_in is valid for sampling this cycle
//   clear_req    request to clear coverage state (has priority over sample_en)
//   clear_ack    one-cycle pulse on the cycle after the CLEAR state
//   valid_out    cover pulses: bit 2i = rise of bit i, bit 2i+1 = fall of bit i
//   num_covered  number of distinct cover points hit since the last reset/clear
//   all_covered  num_covered == 2*SIG_WIDTH
//   armed        prev-value register holds a valid sample
module toggle_cover_detect #(
  parameter int SIG_WIDTH = 32,
  parameter bit DEDUP     = 1'b1
) (
  input  logic                            gbl_clk,
  input  logic                            reset,
  input  logic [SIG_WIDTH-1:0]            sig_in,
  input  logic                            sample_en,
  input  logic                            clear_req,
  output logic                            clear_ack,
  output logic [2*SIG_WIDTH-1:0]          valid_out,
  output logic [$clog2(2*SIG_WIDTH):0]    num_covered,
  output logic                            all_covered,
  output logic                            armed
);

  localparam int CW = 2 * SIG_WIDTH;
  localparam int NW = $clog2(2 * SIG_WIDTH) + 1;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    CLEAR    = 2'd2
  } state_t;

  // Count of set bits in a cover vector.
  function automatic logic [NW-1:0] popcount(input logic [CW-1:0] v);
    logic [NW-1:0] c;
    c = '0;
    for (int i = 0; i < CW; i++) begin
      c = c + {{(NW-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Place rise[i] at bit 2i and fall[i] at bit 2i+1.
  function automatic logic [CW-1:0] interleave(input logic [SIG_WIDTH-1:0] r,
                                               input logic [SIG_WIDTH-1:0] f);
    logic [CW-1:0] v;
    v = '0;
    for (int i = 0; i < SIG_WIDTH; i++) begin
      v[2*i]   = r[i];
      v[2*i+1] = f[i];
    end
    return v;
  endfunction

  state_t               state_r, state_nxt_s;
  logic [SIG_WIDTH-1:0] prev_r, prev_nxt_s;
  logic [CW-1:0]        bitmap_r, bitmap_nxt_s;
  logic [NW-1:0]        count_nxt_s;
  logic [CW-1:0]        valid_nxt_s;
  logic                 ack_nxt_s;
  logic [CW-1:0]        hit_s;
  logic [CW-1:0]        new_s;

  // Toggle detection against the previous sample. This is only used in the ARMED state.
  always_comb begin
    hit_s = interleave(~prev_r & sig_in, prev_r & ~sig_in);
    new_s = hit_s & ~bitmap_r;
  end

  // Next-state and next-output logic. clear_req wins over sample_en.
  always_comb begin
    state_nxt_s  = state_r;
    prev_nxt_s   = prev_r;
    bitmap_nxt_s = bitmap_r;
    count_nxt_s  = num_covered;
    valid_nxt_s  = '0;
    ack_nxt_s    = 1'b0;
    case (state_r)
      DISARMED: begin
        if (clear_req) begin
          state_nxt_s = CLEAR;
        end else if (sample_en) begin
          // The first sample only primes prev; nothing is evaluated yet.
          prev_nxt_s  = sig_in;
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = DISARMED;
        end
      end
      ARMED: begin
        if (clear_req) begin
          state_nxt_s = CLEAR;
        end else if (sample_en) begin
          prev_nxt_s   = sig_in;
          valid_nxt_s  = DEDUP ? new_s : hit_s;
          bitmap_nxt_s = bitmap_r | hit_s;
          // new_s is disjoint from the bitmap, so the count cannot exceed CW.
          count_nxt_s  = num_covered + popcount(new_s);
        end else begin
          state_nxt_s = ARMED;
        end
      end
      CLEAR: begin
        bitmap_nxt_s = '0;
        count_nxt_s  = '0;
        ack_nxt_s    = 1'b1;
        state_nxt_s  = DISARMED;
      end
      default: begin
        state_nxt_s = DISARMED;
      end
    endcase
  end

  // State, coverage and output registers with synchronous active-low reset.
  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      state_r     <= DISARMED;
      prev_r      <= '0;
      bitmap_r    <= '0;
      valid_out   <= '0;
      num_covered <= '0;
      all_covered <= 1'b0;
      clear_ack   <= 1'b0;
      armed       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      prev_r      <= prev_nxt_s;
      bitmap_r    <= bitmap_nxt_s;
      valid_out   <= valid_nxt_s;
      num_covered <= count_nxt_s;
      all_covered <= (count_nxt_s == NW'(CW));
      clear_ack   <= ack_nxt_s;
      armed       <= (state_nxt_s == ARMED);
    end
  end

endmodule

// File: tb/tb_toggle_cover_detect.sv
module tb_toggle_cover_detect;

  logic        gbl_clk;
  logic        reset;
  logic [31:0] sig_in;
  logic        sample_en;
  logic        clear_req;

  logic        ack1, ac1, arm1;
  logic [63:0] v1;
  logic [6:0]  n1;
  logic        ack0, ac0, arm0;
  logic [63:0] v0;
  logic [6:0]  n0;

  int checks;
  int errors;

  toggle_cover_detect #(.SIG_WIDTH(32), .DEDUP(1'b1)) dut1 (
    .gbl_clk(gbl_clk), .reset(reset), .sig_in(sig_in), .sample_en(sample_en),
    .clear_req(clear_req), .clear_ack(ack1), .valid_out(v1), .num_covered(n1),
    .all_covered(ac1), .armed(arm1)
  );

  toggle_cover_detect #(.SIG_WIDTH(32), .DEDUP(1'b0)) dut0 (
    .gbl_clk(gbl_clk), .reset(reset), .sig_in(sig_in), .sample_en(sample_en),
    .clear_req(clear_req), .clear_ack(ack0), .valid_out(v0), .num_covered(n0),
    .all_covered(ac0), .armed(arm0)
  );

  initial gbl_clk = 1'b0;
  always #5 gbl_clk = ~gbl_clk;

  task automatic tick();
    @(posedge gbl_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; sample_en = 1'b0; clear_req = 1'b0; sig_in = 32'h0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic samp(input logic [31:0] s);
    sig_in = s; sample_en = 1'b1; clear_req = 1'b0;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (v1 !== 64'h0) begin errors++; $display("FAIL reset_valid got %h exp 0", v1); end
    checks++; if (n1 !== 7'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", n1); end
    checks++; if ({ack1, ac1, arm1} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {ack1, ac1, arm1}); end
    checks++; if ({ack0, ac0, arm0, n0} !== 10'h0) begin errors++; $display("FAIL reset_d0 got %h exp 0", {ack0, ac0, arm0, n0}); end
  endtask

  task automatic test_prime_toggle();
    do_reset();
    samp(32'h0);
    checks++; if (v1 !== 64'h0) begin errors++; $display("FAIL prime_valid got %h exp 0", v1); end
    checks++; if (arm1 !== 1'b1) begin errors++; $display("FAIL prime_armed got %b exp 1", arm1); end
    samp(32'h1);
    checks++; if (v1 !== 64'h1) begin errors++; $display("FAIL toggle_valid got %h exp 1", v1); end
    checks++; if (n1 !== 7'd1) begin errors++; $display("FAIL toggle_count got %0d exp 1", n1); end
    tick();
    checks++; if (v1 !== 64'h0) begin errors++; $display("FAIL toggle_pulse got %h exp 0", v1); end
  endtask

  task automatic test_dedup();
    logic [31:0] s   [5] = '{32'h0, 32'h1, 32'h0, 32'h1, 32'h0};
    logic [63:0] e1  [5] = '{64'h0, 64'h1, 64'h2, 64'h0, 64'h0};
    logic [63:0] e0  [5] = '{64'h0, 64'h1, 64'h2, 64'h1, 64'h2};
    logic [6:0]  en  [5] = '{7'd0, 7'd1, 7'd2, 7'd2, 7'd2};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      samp(s[i]);
      checks++; if (v1 !== e1[i]) begin errors++; $display("FAIL dedup1_valid[%0d] got %h exp %h", i, v1, e1[i]); end
      checks++; if (v0 !== e0[i]) begin errors++; $display("FAIL dedup0_valid[%0d] got %h exp %h", i, v0, e0[i]); end
      checks++; if (n1 !== en[i]) begin errors++; $display("FAIL dedup1_count[%0d] got %0d exp %0d", i, n1, en[i]); end
      checks++; if (n0 !== en[i]) begin errors++; $display("FAIL dedup0_count[%0d] got %0d exp %0d", i, n0, en[i]); end
    end
  endtask

  task automatic test_full();
    do_reset();
    samp(32'h0);
    samp(32'hFFFF_FFFF);
    checks++; if (v1 !== 64'h5555_5555_5555_5555) begin errors++; $display("FAIL full_rise got %h exp 5555555555555555", v1); end
    checks++; if (n1 !== 7'd32 || ac1 !== 1'b0) begin errors++; $display("FAIL full_half got %0d/%b exp 32/0", n1, ac1); end
    samp(32'h0);
    checks++; if (v1 !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL full_fall got %h exp aaaaaaaaaaaaaaaa", v1); end
    checks++; if (n1 !== 7'd64) begin errors++; $display("FAIL full_count got %0d exp 64", n1); end
    checks++; if (ac1 !== 1'b1 || ac0 !== 1'b1) begin errors++; $display("FAIL full_all got %b%b exp 11", ac1, ac0); end
  endtask

  // Starts from the fully covered, armed state left by test_full (prev=0).
  task automatic test_clear_priority();
    sig_in = 32'h1; sample_en = 1'b1; clear_req = 1'b1;
    tick();
    checks++; if (v1 !== 64'h0 || v0 !== 64'h0) begin errors++; $display("FAIL clr_valid got %h/%h exp 0", v1, v0); end
    checks++; if (arm1 !== 1'b0 || ack1 !== 1'b0) begin errors++; $display("FAIL clr_cyc1 arm/ack got %b%b exp 00", arm1, ack1); end
    sample_en = 1'b0; clear_req = 1'b0;
    tick();
    checks++; if (ack1 !== 1'b1) begin errors++; $display("FAIL clr_ack got %b exp 1", ack1); end
    checks++; if (n1 !== 7'd0 || ac1 !== 1'b0 || arm1 !== 1'b0) begin errors++; $display("FAIL clr_state got %0d/%b/%b exp 0/0/0", n1, ac1, arm1); end
    tick();
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL clr_ack_pulse got %b exp 0", ack1); end
    samp(32'h1);
    checks++; if (v1 !== 64'h0 || arm1 !== 1'b1) begin errors++; $display("FAIL clr_prime got %h/%b exp 0/1", v1, arm1); end
    samp(32'h0);
    checks++; if (v1 !== 64'h2 || n1 !== 7'd1) begin errors++; $display("FAIL clr_after got %h/%0d exp 2/1", v1, n1); end
    // A held clear_req alternates CLEAR and DISARMED, so ack every other cycle.
    clear_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (ack1 !== logic'(i % 2)) begin errors++; $display("FAIL clr_held[%0d] got %b exp %0d", i, ack1, i % 2); end
    end
    clear_req = 1'b0;
  endtask

  task automatic test_gated();
    do_reset();
    samp(32'h0);
    sig_in = 32'h3; sample_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (v1 !== 64'h0) begin errors++; $display("FAIL gated_idle[%0d] got %h exp 0", i, v1); end
    end
    samp(32'h3);
    checks++; if (v1 !== 64'h5 || n1 !== 7'd2) begin errors++; $display("FAIL gated_valid got %h/%0d exp 5/2", v1, n1); end
    tick();
    checks++; if (v1 !== 64'h0) begin errors++; $display("FAIL gated_pulse got %h exp 0", v1); end
  endtask

  // Starts from test_gated: bitmap holds two points, armed, prev=3.
  task automatic test_reset_mid();
    clear_req = 1'b1; reset = 1'b0;
    tick();
    checks++; if ({v1, n1, ack1, ac1, arm1} !== 74'h0) begin errors++; $display("FAIL rstmid_out got %h/%0d/%b%b%b exp 0", v1, n1, ack1, ac1, arm1); end
    reset = 1'b1; clear_req = 1'b0;
    tick();
    checks++; if (ack1 !== 1'b0 || arm1 !== 1'b0) begin errors++; $display("FAIL rstmid_noack got %b%b exp 00", ack1, arm1); end
    samp(32'h1);
    checks++; if (v1 !== 64'h0 || arm1 !== 1'b1) begin errors++; $display("FAIL rstmid_disarmed got %h/%b exp 0/1", v1, arm1); end
    // Reset landing while in CLEAR also suppresses the ack.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0; reset = 1'b0;
    tick();
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rstclr_ack0 got %b exp 0", ack1); end
    reset = 1'b1;
    tick();
    checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL rstclr_ack1 got %b exp 0", ack1); end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; sample_en = 1'b0; clear_req = 1'b0; sig_in = 32'h0;
    test_reset();
    test_prime_toggle();
    test_dedup();
    test_full();
    test_clear_priority();
    test_gated();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
